picorv32_mem_responder: RTL
===========================

// Module: picorv32_mem_responder
// PURPOSE
//  Slave responder for the picorv32 native memory bus. It feeds mem_ready/mem_rdata back to the core.
//  It translates each core request into a single access on a 1-cycle-latency SRAM port.
//  It inserts externally driven wait states, bounded by MAX_WAIT.
//  It flags core-side handshake violations so that formal and simulation harnesses can restrict on them.
// PARAMETERS
//  ADDR_W    10  SRAM word-address width; byte range covered = 4*2**ADDR_W
//  MAX_WAIT  4   max stall cycles per transaction (0 = never stall)
// PORTS
//  clk           in   1        clock
//  resetn        in   1        synchronous, active-low reset
//  mem_valid     in   1        core request valid
//  mem_instr     in   1        request is an instruction fetch
//  mem_addr      in   32       byte address
//  mem_wdata     in   32       write data
//  mem_wstrb     in   4        byte write enables; 0 = read
//  mem_ready     out  1        response strobe (one cycle)
//  mem_rdata     out  32       read data; valid only while mem_ready
//  stall_req     in   1        request a wait state (solver/bench driven)
//  sram_en       out  1        SRAM access strobe
//  sram_we       out  4        SRAM byte write enables
//  sram_addr     out  ADDR_W   SRAM word address = mem_addr[ADDR_W+1:2]
//  sram_wdata    out  32       SRAM write data
//  sram_rdata    in   32       SRAM read data, valid the cycle after sram_en
//  busy          out  1        transaction in flight (state != IDLE)
//  protocol_err  out  1        sticky handshake-violation flag
// BEHAVIOUR
//  - Reset (resetn=0 at posedge): state=IDLE, wait_cnt=0, protocol_err=0, captured request cleared.
//    Then all outputs are 0. Reset mid-transaction discards the transaction; no mem_ready is issued.
//  - FSM states: IDLE, STALL, ISSUE, RESP. All outputs are decoded from registered state/capture.
//  - IDLE: if mem_valid, capture {instr,addr,wdata,wstrb}.
//    Next state is STALL if stall_req && MAX_WAIT>0, else ISSUE.
//  - STALL: wait_cnt increments each cycle.
//    Go to ISSUE when !stall_req or wait_cnt==MAX_WAIT-1. Otherwise stay.
//  - ISSUE: sram_en=1 for exactly one cycle; sram_we=wstrb; sram_addr/sram_wdata come from the capture.
//    Next state: RESP.
//  - Out-of-range request (addr[31:ADDR_W+2]!=0): ISSUE asserts no sram_en.
//    The write is dropped and a read returns 32'h0.
//  - RESP: mem_ready=1 for one cycle.
//    mem_rdata = sram_rdata for an in-range read; 32'h0 for writes and out-of-range accesses.
//    Next state: IDLE, and wait_cnt clears.
//  - Latency: mem_valid first seen at cycle N gives mem_ready at N+2+stalls. Worst case is N+2+MAX_WAIT.
//  - mem_valid still high in IDLE the cycle after RESP is treated as a new request (back-to-back allowed).
//  - Protocol check while in STALL or ISSUE sets protocol_err (sticky until reset) on either:
//    mem_valid low, or any of mem_instr/addr/wdata/wstrb differing from the capture.
//  - Misaligned mem_addr (addr[1:0]!=0) with mem_valid in IDLE also sets protocol_err.
//    The access still proceeds on the truncated word address.
//  - Simultaneous violation and reset: reset wins.
//  - wait_cnt width is $clog2(MAX_WAIT+1). It never wraps because it is bounded by MAX_WAIT.
// STRUCTURE
//  - Package picorv32_mem_pkg holds:
//    - the state enum (IDLE, STALL, ISSUE, RESP);
//    - the mem_req_t struct {instr, addr, wdata, wstrb};
//    - the constant WORD_BYTES=4.
//  - Sub-module picorv32_mem_protocol_monitor compares the live request against the capture.
//    It owns the sticky protocol_err register. The FSM, counter and SRAM drive stay in the top.
// TESTING
//  - Read, no stall: SRAM word 3 = 32'hDEADBEEF; mem_valid at cycle 0 with addr 32'h0C, wstrb=0.
//    -> sram_en at cycle 1, sram_addr=3; mem_ready at cycle 2 with mem_rdata=32'hDEADBEEF.
//  - Write: addr 32'h10, wdata 32'h11223344, wstrb 4'b0101.
//    -> sram_we=4'b0101, sram_addr=4 at cycle 1; mem_ready at cycle 2 with mem_rdata=0.
//  - Stall bound: MAX_WAIT=4, stall_req held high.
//    -> exactly 4 STALL cycles; sram_en at cycle 5; mem_ready at cycle 6.
//  - Out-of-range: ADDR_W=10, addr 32'h0000_1000 read.
//    -> no sram_en; mem_ready at cycle 2 with mem_rdata=0; protocol_err stays 0.
//  - Violation: mem_addr changes 32'h0C -> 32'h10 during STALL.
//    -> protocol_err=1 from the next cycle; it stays 1 through later clean transactions until resetn=0.
//  - Reset mid-op: resetn low during ISSUE.
//    -> no mem_ready; state is IDLE and all outputs are 0 the cycle after release.

Source files
------------

// File: rtl/picorv32_mem_pkg.sv
// Shared types for the picorv32 native-bus memory responder.
package picorv32_mem_pkg;

  localparam int WORD_BYTES = 4;
  localparam int BYTE_OFF_W = $clog2(WORD_BYTES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STALL = 2'd1,
    ISSUE = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef struct packed {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_req_t;

endpackage

// File: rtl/picorv32_mem_protocol_monitor.sv
// Sticky detector for core-side handshake violations: a request must stay
// stable and asserted until it is answered, and must be word aligned.
module picorv32_mem_protocol_monitor
  import picorv32_mem_pkg::*;
(
  input  logic     clk,
  input  logic     resetn,
  input  state_e   state_i,
  input  logic     mem_valid_i,
  input  mem_req_t live_i,
  input  mem_req_t cap_i,
  output logic     protocol_err_o
);

  logic err_q;
  logic err_d;
  logic hold_chk_s;
  logic violation_s;

  // Flag a dropped or altered request while pending, or a misaligned new one
  always_comb begin
    hold_chk_s  = (state_i == STALL) || (state_i == ISSUE);
    violation_s = 1'b0;
    if (hold_chk_s && (!mem_valid_i || (live_i != cap_i))) begin
      violation_s = 1'b1;
    end else if ((state_i == IDLE) && mem_valid_i &&
                 (live_i.addr[BYTE_OFF_W-1:0] != '0)) begin
      violation_s = 1'b1;
    end else begin
      violation_s = 1'b0;
    end
    err_d = err_q | violation_s;
  end

  // Sticky error register, cleared only by reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign protocol_err_o = err_q;

endmodule

// File: rtl/picorv32_mem_responder.sv
// picorv32 native-bus slave: one SRAM access per request, with optional
// externally requested wait states bounded by MAX_WAIT.
module picorv32_mem_responder
  import picorv32_mem_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              mem_valid,
  input  logic              mem_instr,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_wstrb,
  output logic              mem_ready,
  output logic [31:0]       mem_rdata,
  input  logic              stall_req,
  output logic              sram_en,
  output logic [3:0]        sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata,
  output logic              busy,
  output logic              protocol_err
);

  localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0] LAST_WAIT = (MAX_WAIT > 0) ? CNT_W'(MAX_WAIT - 1) : '0;

  state_e            state_q, state_d;
  mem_req_t          req_q, req_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  mem_req_t          live_s;
  logic              in_range_s;
  logic              is_read_s;

  assign live_s     = {mem_instr, mem_addr, mem_wdata, mem_wstrb};
  assign in_range_s = (req_q.addr >> (ADDR_W + BYTE_OFF_W)) == 32'd0;
  assign is_read_s  = (req_q.wstrb == 4'b0000);

  // Next-state, capture and wait counter
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      IDLE: begin
        if (mem_valid) begin
          req_d   = live_s;
          state_d = (stall_req && (MAX_WAIT > 0)) ? STALL : ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      STALL: begin
        wait_cnt_d = wait_cnt_q + CNT_W'(1);
        if (!stall_req || (wait_cnt_q == LAST_WAIT)) begin
          state_d = ISSUE;
        end else begin
          state_d = STALL;
        end
      end
      ISSUE: state_d = RESP;
      RESP: begin
        state_d    = IDLE;
        wait_cnt_d = '0;
      end
      default: begin
        state_d    = IDLE;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Output decode; out-of-range requests never touch the SRAM and read as zero
  always_comb begin
    sram_en    = 1'b0;
    sram_we    = 4'b0000;
    sram_addr  = '0;
    sram_wdata = 32'h0;
    mem_ready  = 1'b0;
    mem_rdata  = 32'h0;
    case (state_q)
      ISSUE: begin
        sram_en    = in_range_s;
        sram_we    = in_range_s ? req_q.wstrb : 4'b0000;
        sram_addr  = req_q.addr[ADDR_W+BYTE_OFF_W-1:BYTE_OFF_W];
        sram_wdata = req_q.wdata;
      end
      RESP: begin
        mem_ready = 1'b1;
        mem_rdata = (in_range_s && is_read_s) ? sram_rdata : 32'h0;
      end
      default: begin
        mem_ready = 1'b0;
      end
    endcase
  end

  assign busy = (state_q != IDLE);

  // State, capture and counter registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      req_q      <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  picorv32_mem_protocol_monitor u_mon (
    .clk            (clk),
    .resetn         (resetn),
    .state_i        (state_q),
    .mem_valid_i    (mem_valid),
    .live_i         (live_s),
    .cap_i          (req_q),
    .protocol_err_o (protocol_err)
  );

endmodule
